// File: rtl/jump_pc_read_scheduler_pkg.sv
// Shared widths, slot-state encoding and response type for the jump PC read scheduler.
package jump_pc_read_scheduler_pkg;

    localparam int FTQ_IDX_W = 6;
    localparam int FTQ_OFF_W = 4;
    localparam int VADDR_W   = 39;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_WAIT = 2'd1,
        SLOT_FULL = 2'd2
    } slotState_e;

    typedef struct packed {
        logic [VADDR_W-1:0] jumpPc;
        logic [VADDR_W-1:0] jalrTarget;
    } jumpResp_t;

    // The offset counts 2-byte parcels; the carry out of VADDR_W is dropped on purpose.
    function automatic logic [VADDR_W-1:0] calcJumpPc(
        input logic [VADDR_W-1:0]   startAddr,
        input logic [FTQ_OFF_W-1:0] ftqOffset
    );
        logic [VADDR_W-1:0] byteOff;
        byteOff = {{(VADDR_W-FTQ_OFF_W-1){1'b0}}, ftqOffset, 1'b0};
        return startAddr + byteOff;
    endfunction

endpackage

// File: rtl/jump_pc_read_scheduler_rr_arbiter.sv
// Round-robin single-grant arbiter: priority starts at ptr_i and wraps modulo N.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(N);

    int               slotSum;
    logic [IDX_W-1:0] slotIdx;

    // Walk from lowest to highest priority so the closest requester to ptr_i wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        slotSum     = 0;
        slotIdx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            slotSum = int'(ptr_i) + k;
            if (slotSum >= N) begin
                slotSum = slotSum - N;
            end
            slotIdx = IDX_W'(slotSum);
            if (req_i[slotIdx]) begin
                grant_o          = '0;
                grant_o[slotIdx] = 1'b1;
                grant_idx_o      = slotIdx;
            end
        end
    end

endmodule

// File: rtl/jump_pc_read_scheduler.sv
// Shares the FTQ PC-memory read port among jump issue slots and buffers one
// {jump_pc, jalr_target} response per slot.
module jump_pc_read_scheduler
    import jump_pc_read_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_flush,
    input  logic [NUM_REQ-1:0]           io_req_valid,
    output logic [NUM_REQ-1:0]           io_req_ready,
    input  logic [NUM_REQ*FTQ_IDX_W-1:0] io_req_ftqIdx,
    input  logic [NUM_REQ*FTQ_OFF_W-1:0] io_req_ftqOffset,
    output logic                         io_pcmem_ren,
    output logic [FTQ_IDX_W-1:0]         io_pcmem_raddr,
    input  logic [VADDR_W-1:0]           io_pcmem_rdata_startAddr,
    input  logic [VADDR_W-1:0]           io_pcmem_rdata_target,
    output logic [NUM_REQ-1:0]           io_resp_valid,
    input  logic [NUM_REQ-1:0]           io_resp_ready,
    output logic [NUM_REQ*VADDR_W-1:0]   io_resp_jump_pc,
    output logic [NUM_REQ*VADDR_W-1:0]   io_resp_jalr_target
);

    localparam int PTR_W = $clog2(NUM_REQ);

    slotState_e           state_q  [NUM_REQ];
    slotState_e           state_d  [NUM_REQ];
    logic [FTQ_OFF_W-1:0] offset_q [NUM_REQ];
    logic [FTQ_OFF_W-1:0] offset_d [NUM_REQ];
    jumpResp_t            resp_q   [NUM_REQ];
    jumpResp_t            resp_d   [NUM_REQ];
    logic [PTR_W-1:0]     rrPtr_q;
    logic [PTR_W-1:0]     rrPtr_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grantIdx;
    logic                 anyGrant;

    // Ready ignores the grant; an accepted request that loses arbitration stays pending.
    always_comb begin
        io_req_ready = '0;
        eligible     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            io_req_ready[i] = (state_q[i] == SLOT_IDLE) && !io_flush;
            eligible[i]     = io_req_valid[i] && (state_q[i] == SLOT_IDLE) && !io_flush && !reset;
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arbiter (
        .req_i       (eligible),
        .ptr_i       (rrPtr_q),
        .grant_o     (grant),
        .grant_idx_o (grantIdx)
    );

    always_comb begin
        anyGrant       = |grant;
        io_pcmem_ren   = anyGrant;
        io_pcmem_raddr = '0;
        rrPtr_d        = rrPtr_q;
        if (anyGrant) begin
            io_pcmem_raddr = io_req_ftqIdx[int'(grantIdx)*FTQ_IDX_W +: FTQ_IDX_W];
            rrPtr_d        = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
        end
    end

    // Per-slot FSM: a flush wins over everything, including rdata arriving for a WAIT slot.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i]  = state_q[i];
            offset_d[i] = offset_q[i];
            resp_d[i]   = resp_q[i];
            if (io_flush) begin
                state_d[i] = SLOT_IDLE;
            end else begin
                case (state_q[i])
                    SLOT_IDLE: begin
                        if (grant[i]) begin
                            state_d[i]  = SLOT_WAIT;
                            offset_d[i] = io_req_ftqOffset[i*FTQ_OFF_W +: FTQ_OFF_W];
                        end
                    end
                    SLOT_WAIT: begin
                        resp_d[i].jumpPc     = calcJumpPc(io_pcmem_rdata_startAddr, offset_q[i]);
                        resp_d[i].jalrTarget = io_pcmem_rdata_target;
                        state_d[i]           = SLOT_FULL;
                    end
                    SLOT_FULL: begin
                        if (io_resp_ready[i]) begin
                            state_d[i] = SLOT_IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = SLOT_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i]  <= SLOT_IDLE;
                offset_q[i] <= '0;
                resp_q[i]   <= '0;
            end
        end else begin
            rrPtr_q <= rrPtr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i]  <= state_d[i];
                offset_q[i] <= offset_d[i];
                resp_q[i]   <= resp_d[i];
            end
        end
    end

    always_comb begin
        io_resp_valid       = '0;
        io_resp_jump_pc     = '0;
        io_resp_jalr_target = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            io_resp_valid[i]                        = (state_q[i] == SLOT_FULL);
            io_resp_jump_pc[i*VADDR_W +: VADDR_W]     = resp_q[i].jumpPc;
            io_resp_jalr_target[i*VADDR_W +: VADDR_W] = resp_q[i].jalrTarget;
        end
    end

endmodule

// File: doc/jump_pc_read_scheduler.md
Name: jump_pc_read_scheduler

Overview:
- Shares the single FTQ PC-memory read port among the reservation-station issue slots that issue jump/branch uops.
- Each slot requests the PC and JALR target of its uop by FTQ index and offset. The block arbitrates round-robin, sequences the 1-cycle memory read, forms jump_pc, and buffers one response per slot.
- Downstream, the buffered jump_pc and jalr_target feed the data-array immediate path.

Parameters:
- NUM_REQ, 2, number of requesting issue slots (>=2).
- FTQ_IDX_W, 6, FTQ entry index width.
- FTQ_OFF_W, 4, instruction offset within an FTQ entry, in 2-byte units.
- VADDR_W, 39, virtual address width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- io_flush  in  1  redirect; drops all pending and buffered work.
- io_req_valid  in  NUM_REQ  per-slot request valid.
- io_req_ready  out  NUM_REQ  per-slot request accept.
- io_req_ftqIdx  in  NUM_REQ*FTQ_IDX_W  per-slot FTQ index; slot i occupies bits [i*FTQ_IDX_W +: FTQ_IDX_W].
- io_req_ftqOffset  in  NUM_REQ*FTQ_OFF_W  per-slot offset, packed the same way.
- io_pcmem_ren  out  1  PC-memory read enable.
- io_pcmem_raddr  out  FTQ_IDX_W  PC-memory read index.
- io_pcmem_rdata_startAddr  in  VADDR_W  entry start address; valid the cycle after ren.
- io_pcmem_rdata_target  in  VADDR_W  entry predicted/JALR target; valid the cycle after ren.
- io_resp_valid  out  NUM_REQ  per-slot response valid.
- io_resp_ready  in  NUM_REQ  per-slot response consume.
- io_resp_jump_pc  out  NUM_REQ*VADDR_W  per-slot jump PC, packed.
- io_resp_jalr_target  out  NUM_REQ*VADDR_W  per-slot JALR target, packed.

Behaviour:
- Per-slot FSM with states IDLE, WAIT, FULL. Reset: all slots IDLE, rr_ptr=0, every output 0, response registers 0.
- io_req_ready[i] = (state[i]==IDLE) && !io_flush. The ready is not gated by the grant.
  - A request accepted but not granted stays pending: the slot keeps valid high and its fields stable until granted.
  - Dropping valid before grant is legal and withdraws the request.
- Eligible slot: valid && IDLE && !io_flush.
- Arbiter: at most one grant per cycle. Priority starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On grant to slot g: rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Grant cycle (T):
  - io_pcmem_ren=1 and io_pcmem_raddr=ftqIdx[g].
  - Latch ftqOffset[g]; state[g] <= WAIT.
  - When nothing is granted: io_pcmem_ren=0 and io_pcmem_raddr=0.
- T+1, slot in WAIT:
  - jump_pc = (startAddr + {ftqOffset, 1'b0}) truncated to VADDR_W; the carry-out is discarded (wrap).
  - jalr_target = target.
  - Both are registered; state <= FULL.
- FULL: io_resp_valid=1 starting T+2, so latency from grant to resp_valid is 2 cycles.
  - Data holds stable while valid && !ready.
  - On io_resp_ready: state <= IDLE, and resp_valid drops the next cycle.
  - The slot can be granted again no earlier than 1 cycle after leaving FULL; per-slot throughput is 1 per 3 cycles minimum.
- io_resp_ready while not FULL is ignored.
- io_flush: every slot goes to IDLE next cycle, and all io_resp_valid are 0 the next cycle. In the flush cycle itself:
  - no grant, and io_pcmem_ren=0;
  - rdata returning to a WAIT slot is discarded;
  - a coincident resp handshake is still considered consumed.
- Reset mid-operation overrides everything: same as the reset state, with in-flight rdata discarded.
- io_pcmem_ren is never asserted in two slots' names at once; only the single granted index is driven.

Decomposition:
- Shared package holds:
  - constants FTQ_IDX_W, FTQ_OFF_W, VADDR_W;
  - the slot-state enum {IDLE, WAIT, FULL};
  - a packed struct {jump_pc, jalr_target} for the response.
- One sub-module: rr_arbiter. Parameter N; inputs req[N] and ptr; outputs one-hot grant[N] and grant_idx.
- The per-slot FSMs and the response registers stay in the top.

Test Plan:
- Single request: slot0 valid, ftqIdx=5, offset=3, startAddr=0x80000000, target=0x80001000 -> ren=1 and raddr=5 at T; resp_valid[0]=1 at T+2 with jump_pc=0x80000006 and jalr_target=0x80001000.
- Contention: both slots valid every cycle from reset, resp_ready=1 -> grants alternate slot0, slot1, slot0, ...; rr_ptr toggles; no cycle has two grants.
- Backpressure: slot1 FULL, resp_ready=0 for 5 cycles -> resp_valid and data stable; req_ready[1]=0; slot0 keeps getting grants.
- Wrap arithmetic: startAddr=0x7FFFFFFFFE, offset=2 -> jump_pc=0x0000000002.
- Flush in WAIT: grant slot0 at T, io_flush=1 at T+1 -> resp_valid[0] stays 0; slot0 IDLE at T+2; ren=0 at T+1.
- Reset during FULL: assert reset 1 cycle -> all resp_valid=0, rr_ptr=0, req_ready all 1 next cycle.
